// File: rtl/bip_data_mem.sv
// rtl/bip_data_mem.sv - BIP data-side RAM responder, 1-cycle registered reads, read-before-write.
// Define BIP_DATA_MEM_MMIO_EN to map GPIO/counter/compare/status registers over the top 16 words.
module bip_data_mem #(
  parameter int                ADDR_W    = 11,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 11'h7F0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [DATA_W-1:0] In_Data,
  output logic [DATA_W-1:0] Out_Data,
  input  logic [DATA_W-1:0] Gpio_In,
  output logic [DATA_W-1:0] Gpio_Out,
  output logic              Timer_Flag
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ram_we;

  assign ram_rdata = mem[DataAddr];

  // Gating with Reset drops any write strobe seen while reset is held.
  always_ff @(posedge Clock) begin
    if (ram_we) mem[DataAddr] <= In_Data;
  end

`ifdef BIP_DATA_MEM_MMIO_EN
  logic [ADDR_W-1:0] off;
  logic              hit;
  logic [DATA_W-1:0] gpio_out_q, gpio_out_d;
  logic [DATA_W-1:0] sync1_q, sync2_q;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              flag_q, flag_d;
  logic              flag_set, flag_clr;
  logic [DATA_W-1:0] mmio_rdata;

  assign off = DataAddr - MMIO_BASE;
  assign hit = (DataAddr >= MMIO_BASE) && (off < ADDR_W'(16));
  assign ram_we = Wr && Reset && !hit;

  always_comb begin
    mmio_rdata = '0;
    case (off[3:0])
      4'd0:    mmio_rdata = gpio_out_q;
      4'd1:    mmio_rdata = sync2_q;
      4'd2:    mmio_rdata = count_q;
      4'd3:    mmio_rdata = cmp_q;
      4'd4:    mmio_rdata = {{(DATA_W-1){1'b0}}, flag_q};
      default: mmio_rdata = '0;
    endcase
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    count_d    = count_q + DATA_W'(1);
    cmp_d      = cmp_q;
    flag_clr   = 1'b0;
    if (Wr && hit) begin
      case (off[3:0])
        4'd0:    gpio_out_d = In_Data;
        4'd2:    count_d    = In_Data;
        4'd3:    cmp_d      = In_Data;
        4'd4:    flag_clr   = In_Data[0];
        default: ;
      endcase
    end
    // Match uses the pre-increment count; a simultaneous clear loses to a set.
    flag_set = (cmp_q != '0) && (count_q == cmp_q);
    flag_d   = flag_set || (flag_q && !flag_clr);
    out_d    = Rd ? (hit ? mmio_rdata : ram_rdata) : out_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= Gpio_In;
      sync2_q    <= sync1_q;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      flag_q     <= flag_d;
    end
  end

  assign Gpio_Out   = gpio_out_q;
  assign Timer_Flag = flag_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{Gpio_In, MMIO_BASE};
  assign ram_we        = Wr && Reset;
  assign out_d         = Rd ? ram_rdata : out_q;
  assign Gpio_Out      = '0;
  assign Timer_Flag    = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign Out_Data = out_q;

endmodule

// File: tb/tb_bip_data_mem.sv
// tb/tb_bip_data_mem.sv - directed self-checking bench for bip_data_mem.
module tb_bip_data_mem;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [10:0] DataAddr;
  logic        Rd;
  logic        Wr;
  logic [15:0] In_Data;
  logic [15:0] Out_Data;
  logic [15:0] Gpio_In;
  logic [15:0] Gpio_Out;
  logic        Timer_Flag;

  int pass_cnt = 0;
  int total_cnt = 0;

  bip_data_mem dut (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .Rd(Rd), .Wr(Wr),
    .In_Data(In_Data), .Out_Data(Out_Data), .Gpio_In(Gpio_In),
    .Gpio_Out(Gpio_Out), .Timer_Flag(Timer_Flag)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_write(input logic [10:0] a, input logic [15:0] d);
    DataAddr = a; In_Data = d; Wr = 1'b1;
    tick();
    Wr = 1'b0;
  endtask

  task automatic do_read(input logic [10:0] a);
    DataAddr = a; Rd = 1'b1;
    tick();
    Rd = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Rd = 1'b0; Wr = 1'b0; DataAddr = '0; In_Data = '0; Gpio_In = '0;
    repeat (2) tick();
    total_cnt++;
    if (Out_Data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", Out_Data);
    else pass_cnt++;
    total_cnt++;
    if (Gpio_Out !== 16'h0000) $display("FAIL reset_gpio_out got %h want 0000", Gpio_Out);
    else pass_cnt++;
    total_cnt++;
    if (Timer_Flag !== 1'b0) $display("FAIL reset_timer_flag got %b want 0", Timer_Flag);
    else pass_cnt++;
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [10:0] addrs [5];
    logic [15:0] datas [5];
    addrs = '{11'h002, 11'h400, 11'h3FF, 11'h7EF, 11'h401};
    datas = '{16'hFFFF, 16'h8001, 16'h1357, 16'h2468, 16'h0F0F};
    do_write(11'h000, 16'h0000);
    do_read(11'h000);
    total_cnt++;
    if (Out_Data !== 16'h0000) $display("FAIL read_addr0 got %h want 0000", Out_Data);
    else pass_cnt++;
    do_write(11'h001, 16'h5555);
    total_cnt++;
    if (Out_Data !== 16'h0000) $display("FAIL write_no_read got %h want 0000", Out_Data);
    else pass_cnt++;
    do_read(11'h001);
    total_cnt++;
    if (Out_Data !== 16'h5555) $display("FAIL read_5555 got %h want 5555", Out_Data);
    else pass_cnt++;
    DataAddr = 11'h002;
    repeat (2) tick();
    total_cnt++;
    if (Out_Data !== 16'h5555) $display("FAIL hold_no_rd got %h want 5555", Out_Data);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) do_write(addrs[i], datas[i]);
    for (int i = 0; i < 5; i++) begin
      do_read(addrs[i]);
      total_cnt++;
      if (Out_Data !== datas[i]) $display("FAIL pattern_%0d addr %h got %h want %h", i, addrs[i], Out_Data, datas[i]);
      else pass_cnt++;
    end
    do_read(11'h001);
    total_cnt++;
    if (Out_Data !== 16'h5555) $display("FAIL no_alias got %h want 5555", Out_Data);
    else pass_cnt++;
  endtask

  task automatic test_read_before_write();
    do_write(11'h010, 16'h1234);
    DataAddr = 11'h010; In_Data = 16'hBEEF; Rd = 1'b1; Wr = 1'b1;
    tick();
    Rd = 1'b0; Wr = 1'b0;
    total_cnt++;
    if (Out_Data !== 16'h1234) $display("FAIL rbw_old got %h want 1234", Out_Data);
    else pass_cnt++;
    do_read(11'h010);
    total_cnt++;
    if (Out_Data !== 16'hBEEF) $display("FAIL rbw_new got %h want beef", Out_Data);
    else pass_cnt++;
  endtask

  task automatic test_top_word();
    logic [15:0] exp;
`ifdef BIP_DATA_MEM_MMIO_EN
    exp = 16'h0000;
`else
    exp = 16'hA5A5;
`endif
    do_write(11'h7FF, 16'hA5A5);
    do_read(11'h7FF);
    total_cnt++;
    if (Out_Data !== exp) $display("FAIL top_word got %h want %h", Out_Data, exp);
    else pass_cnt++;
    total_cnt++;
    if (Gpio_Out !== 16'h0000) $display("FAIL top_word_gpio got %h want 0000", Gpio_Out);
    else pass_cnt++;
  endtask

`ifdef BIP_DATA_MEM_MMIO_EN
  task automatic test_timer();
    do_write(11'h7F2, 16'hFFFE);
    do_write(11'h7F3, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (Timer_Flag !== 1'b0) $display("FAIL flag_early_%0d got %b want 0", i, Timer_Flag);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (Timer_Flag !== 1'b1) $display("FAIL flag_match got %b want 1", Timer_Flag);
    else pass_cnt++;
    do_read(11'h7F4);
    total_cnt++;
    if (Out_Data !== 16'h0001) $display("FAIL status_read got %h want 0001", Out_Data);
    else pass_cnt++;
    do_write(11'h7F4, 16'h0001);
    total_cnt++;
    if (Timer_Flag !== 1'b0) $display("FAIL flag_clear got %b want 0", Timer_Flag);
    else pass_cnt++;
    do_write(11'h7F2, 16'h0003);
    total_cnt++;
    if (Timer_Flag !== 1'b0) $display("FAIL flag_after_load got %b want 0", Timer_Flag);
    else pass_cnt++;
    do_write(11'h7F4, 16'h0001);
    total_cnt++;
    if (Timer_Flag !== 1'b1) $display("FAIL set_wins got %b want 1", Timer_Flag);
    else pass_cnt++;
    do_read(11'h7F2);
    total_cnt++;
    if (Out_Data !== 16'h0004) $display("FAIL count_read got %h want 0004", Out_Data);
    else pass_cnt++;
  endtask

  task automatic test_gpio();
    Gpio_In = 16'h00F0;
    do_read(11'h7F1);
    total_cnt++;
    if (Out_Data !== 16'h0000) $display("FAIL gpio_in_edge1 got %h want 0000", Out_Data);
    else pass_cnt++;
    do_read(11'h7F1);
    total_cnt++;
    if (Out_Data !== 16'h0000) $display("FAIL gpio_in_edge2 got %h want 0000", Out_Data);
    else pass_cnt++;
    do_read(11'h7F1);
    total_cnt++;
    if (Out_Data !== 16'h00F0) $display("FAIL gpio_in_edge3 got %h want 00f0", Out_Data);
    else pass_cnt++;
    do_write(11'h7F1, 16'hFFFF);
    do_read(11'h7F1);
    total_cnt++;
    if (Out_Data !== 16'h00F0) $display("FAIL gpio_in_ro got %h want 00f0", Out_Data);
    else pass_cnt++;
    do_write(11'h7F0, 16'h0F0F);
    total_cnt++;
    if (Gpio_Out !== 16'h0F0F) $display("FAIL gpio_out got %h want 0f0f", Gpio_Out);
    else pass_cnt++;
    do_read(11'h7F0);
    total_cnt++;
    if (Out_Data !== 16'h0F0F) $display("FAIL gpio_out_read got %h want 0f0f", Out_Data);
    else pass_cnt++;
  endtask
`endif

  task automatic test_async_reset();
    do_read(11'h001);
    #2;
    Reset = 1'b0;
    #1;
    total_cnt++;
    if (Out_Data !== 16'h0000) $display("FAIL async_out_data got %h want 0000", Out_Data);
    else pass_cnt++;
    total_cnt++;
    if (Gpio_Out !== 16'h0000) $display("FAIL async_gpio_out got %h want 0000", Gpio_Out);
    else pass_cnt++;
    total_cnt++;
    if (Timer_Flag !== 1'b0) $display("FAIL async_flag got %b want 0", Timer_Flag);
    else pass_cnt++;
    @(negedge Clock);
    DataAddr = 11'h001; In_Data = 16'h0000; Wr = 1'b1;
    tick();
    Wr = 1'b0;
    Reset = 1'b1;
    do_read(11'h001);
    total_cnt++;
    if (Out_Data !== 16'h5555) $display("FAIL ram_kept got %h want 5555", Out_Data);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_write_read();
    test_read_before_write();
    test_top_word();
`ifdef BIP_DATA_MEM_MMIO_EN
    test_timer();
    test_gpio();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bip_data_mem.md
Name: bip_data_mem

Overview:
- Data-memory responder for the BIP CPU's data-side bus.
- Serves CPU reads and writes from a 2048 x 16 single-port RAM and returns read data one clock later.
- When compiled with the MMIO feature, the top 16 words become memory-mapped registers: GPIO, free-running counter and compare flag.
- Instantiated beside the CPU in the system top; the instruction ROM is a separate block.

Parameters:
- ADDR_W, 11, address width; RAM depth is 2**ADDR_W.
- DATA_W, 16, data word width.
- MMIO_BASE, 11'h7F0, first address of the 16-word MMIO window (feature-enabled only).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- DataAddr  in  ADDR_W  word address from the CPU.
- Rd  in  1  read strobe; sampled on the rising edge.
- Wr  in  1  write strobe; sampled on the rising edge.
- In_Data  in  DATA_W  write data from the CPU.
- Out_Data  out  DATA_W  registered read data to the CPU.
- Gpio_In  in  DATA_W  external input pins, asynchronous to Clock.
- Gpio_Out  out  DATA_W  output register.
- Timer_Flag  out  1  sticky compare-match flag.

Behaviour:
- Reset low, asynchronous:
  - Out_Data = 0, Gpio_Out = 0, counter = 0, compare = 0, Timer_Flag = 0, Gpio_In synchronizer flops = 0.
  - RAM contents are not cleared.
  - A strobe in flight when reset asserts is discarded. The first edge after release behaves normally.
- Write (Wr=1 at an edge): In_Data stored at DataAddr on that edge. No acknowledge; single-cycle write.
- Read (Rd=1 at an edge): Out_Data takes mem[DataAddr] on that edge, giving 1-cycle latency. Out_Data holds its value while Rd=0.
- Rd=1 and Wr=1 at the same edge, same address: the write commits and Out_Data returns the old (pre-write) value, i.e. read-before-write.
- Neither strobe: no state change except the counter, synchronizer and flag logic.
- Address arithmetic: full ADDR_W decode, no wrap or aliasing. 11'h7FF is a valid RAM word when MMIO is disabled.
- MMIO map, offset from MMIO_BASE (feature-enabled only):
  - 0: GPIO_OUT, R/W; drives Gpio_Out.
  - 1: GPIO_IN, RO; Gpio_In after a 2-flop synchronizer, so 2-cycle latency. Writes are ignored.
  - 2: COUNT, R/W; 16-bit free-running counter, +1 every clock, wraps FFFF to 0000. A write loads In_Data on that edge with no increment that cycle.
  - 3: COMPARE, R/W.
  - 4: STATUS, bit0 = Timer_Flag, other bits read 0; writing 1 to bit0 clears the flag.
  - 5-15: read 0, writes ignored.
- Flag rule:
  - Set on the edge where COMPARE != 0 and the pre-increment COUNT == COMPARE.
  - A set and a clear on the same edge: set wins.
- MMIO accesses never touch the underlying RAM words.

Optional Feature:
- Macro: BIP_DATA_MEM_MMIO_EN
- Defined: the MMIO window, counter, synchronizer and flag behave as described above.
- Undefined:
  - All 2048 words are plain RAM, including MMIO_BASE..7FF.
  - Gpio_Out is tied to 0 and Timer_Flag to 0; Gpio_In is ignored.
  - The counter and synchronizer are not built.

Test Plan:
- Reset low for 2 edges, release; Rd=1, addr 0x000 -> Out_Data = 0x0000 after reset; write 0x5555 @0x001, then read @0x001 -> Out_Data = 0x5555 one edge after the read strobe.
- Rd=Wr=1, addr 0x010 holding 0x1234, In_Data = 0xBEEF -> Out_Data = 0x1234; next read of 0x010 -> 0xBEEF.
- Write 0xA5A5 @0x7FF, then read @0x7FF: without the macro -> 0xA5A5; with the macro -> 0x0000, and Gpio_Out unchanged.
- Macro on: write COUNT = 0xFFFE and COMPARE = 0x0003 -> count wraps through 0x0000; Timer_Flag rises on the edge where COUNT = 0x0003, with no flag at wrap; write STATUS = 0x0001 -> flag clears; clear on a matching edge -> flag stays 1.
- Macro on: Gpio_In = 0x00F0 -> read of GPIO_IN returns 0x00F0 only after 2 edges; write GPIO_OUT = 0x0F0F -> Gpio_Out = 0x0F0F; assert Reset mid-test -> Gpio_Out = 0 and Out_Data = 0 immediately, without waiting for a clock.
